// File: rtl/exe_mdu_pkg.sv
// exe_mdu_pkg: shared definitions for the Execute-stage multiply/divide unit.
//   - MDU op code constants (4-bit op field)
//   - sequencer state encoding
//   - op classifiers (is_muldiv / is_div) and the IS_MULDIV macro wrapper
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (codes 9-12).
package exe_mdu_pkg;

  localparam int MDU_OP_W = 4;
  typedef logic [MDU_OP_W-1:0] mdu_op_t;

  localparam mdu_op_t OP_NONE  = 4'd0;
  localparam mdu_op_t OP_MULT  = 4'd1;
  localparam mdu_op_t OP_MULTU = 4'd2;
  localparam mdu_op_t OP_DIV   = 4'd3;
  localparam mdu_op_t OP_DIVU  = 4'd4;
  localparam mdu_op_t OP_MTHI  = 4'd5;
  localparam mdu_op_t OP_MTLO  = 4'd6;
  localparam mdu_op_t OP_MFHI  = 4'd7;
  localparam mdu_op_t OP_MFLO  = 4'd8;
  localparam mdu_op_t OP_MADD  = 4'd9;
  localparam mdu_op_t OP_MADDU = 4'd10;
  localparam mdu_op_t OP_MSUB  = 4'd11;
  localparam mdu_op_t OP_MSUBU = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles and commit to HI/LO.
  function automatic logic is_muldiv(mdu_op_t op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  // Ops that take the long (divide) latency.
  function automatic logic is_div(mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

`ifndef IS_MULDIV
`define IS_MULDIV(op) exe_mdu_pkg::is_muldiv(op)
`endif

// File: rtl/mdu_core_arith.sv
// mdu_core_arith: purely combinational 64-bit result generator for the MDU.
// Ports:
//   op_i            MDU op code
//   rs_i, rt_i      operands (rs = multiplicand / dividend)
//   hi_i, lo_i      current HI/LO (accumulator for madd/msub, kept on div-by-zero)
//   pend_hi_o/lo_o  result to be committed to HI/LO
//   div_zero_o      divide op with a zero divisor
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
module mdu_core_arith
  import exe_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         rs_i,
  input  logic [31:0]         rt_i,
  input  logic [31:0]         hi_i,
  input  logic [31:0]         lo_i,
  output logic [31:0]         pend_hi_o,
  output logic [31:0]         pend_lo_o,
  output logic                div_zero_o
);

  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic        [63:0] prod_u, acc;
  logic signed [31:0] dvd_s, dvs_s, quot_s, rem_s;
  logic        [31:0] dvs_u, quot_u, rem_u;
  logic               rt_zero, div_ovf;

  assign rs_sx  = $signed({{32{rs_i[31]}}, rs_i});
  assign rt_sx  = $signed({{32{rt_i[31]}}, rt_i});
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};
  assign acc    = {hi_i, lo_i};

  assign rt_zero    = (rt_i == 32'd0);
  assign div_zero_o = rt_zero && is_div(op_i);

  // -2^31 / -1 overflows 32-bit signed division; dividing by 1 instead
  // yields the wrapped quotient 0x80000000 with remainder 0.
  // A zero divisor is also swapped for 1 so the dividers never see 0.
  assign div_ovf = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);
  assign dvd_s   = $signed(rs_i);
  assign dvs_s   = (rt_zero || div_ovf) ? 32'sd1 : $signed(rt_i);
  assign quot_s  = dvd_s / dvs_s;
  assign rem_s   = dvd_s % dvs_s;
  assign dvs_u   = rt_zero ? 32'd1 : rt_i;
  assign quot_u  = rs_i / dvs_u;
  assign rem_u   = rs_i % dvs_u;

  always_comb begin
    {pend_hi_o, pend_lo_o} = acc;
    case (op_i)
      OP_MULT:  {pend_hi_o, pend_lo_o} = prod_s;
      OP_MULTU: {pend_hi_o, pend_lo_o} = prod_u;
      OP_DIV:   if (!rt_zero) {pend_hi_o, pend_lo_o} = {rem_s, quot_s};
      OP_DIVU:  if (!rt_zero) {pend_hi_o, pend_lo_o} = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      OP_MADD:  {pend_hi_o, pend_lo_o} = acc + prod_s;
      OP_MADDU: {pend_hi_o, pend_lo_o} = acc + prod_u;
      OP_MSUB:  {pend_hi_o, pend_lo_o} = acc - prod_s;
      OP_MSUBU: {pend_hi_o, pend_lo_o} = acc - prod_u;
`endif
      default:  {pend_hi_o, pend_lo_o} = acc;
    endcase
  end

endmodule

// File: rtl/exe_mdu.sv
// exe_mdu: Execute-stage multiply/divide unit. Owns HI/LO, sequences
// multi-cycle mult/div, and reports busy/stall to the hazard unit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start_i, op_i     MDU instruction valid in E, and its op code
//   rs_val_i/rt_val_i forwarded operands
//   cancel_i          flush: abort in-flight op, suppress start
//   busy_o            multi-cycle op in progress
//   stall_md_o        hazard request (busy, or a mult/div being started)
//   hi_o, lo_o        architectural HI/LO
//   rd_val_o          mfhi/mflo read value (combinational)
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, MULT latency).
module exe_mdu
  import exe_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [31:0]         rs_val_i,
  input  logic [31:0]         rt_val_i,
  input  logic                cancel_i,
  output logic                busy_o,
  output logic                stall_md_o,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o,
  output logic [31:0]         rd_val_o
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [31:0]      ar_hi, ar_lo;
  logic             ar_dz;

  // HI/LO are sampled at start, which is what madd/msub accumulate onto.
  mdu_core_arith u_arith (
    .op_i       (op_i),
    .rs_i       (rs_val_i),
    .rt_i       (rt_val_i),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .pend_hi_o  (ar_hi),
    .pend_lo_o  (ar_lo),
    .div_zero_o (ar_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !cancel_i) begin
          if (is_muldiv(op_i)) begin
            pend_hi_d = ar_hi;
            pend_lo_d = ar_lo;
            pend_dz_d = ar_dz;
            cnt_d     = is_div(op_i) ? CNT_DIV : CNT_MUL;
            state_d   = S_RUN;
          end else if (op_i == OP_MTHI) begin
            hi_d = rs_val_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = rs_val_i;
          end
        end
      end
      S_RUN: begin
        // cancel wins even on the commit cycle
        if (cancel_i) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
          pend_dz_d = 1'b0;
        end else if (cnt_q == CNT_ONE) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q == S_RUN);
  assign stall_md_o = busy_o | (start_i & is_muldiv(op_i) & ~cancel_i);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

  always_comb begin
    rd_val_o = 32'd0;
    if (op_i == OP_MFHI)      rd_val_o = hi_q;
    else if (op_i == OP_MFLO) rd_val_o = lo_q;
  end

`ifndef SYNTHESIS
  // The hazard unit holds new MDU ops while busy; a start here is dropped.
  always_ff @(posedge clk) begin
    assert (reset || !(busy_o && start_i))
      else $error("exe_mdu: start asserted while busy");
  end
`endif

endmodule

// File: tb/tb_exe_mdu.sv
module tb_exe_mdu;
  import exe_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        busy, stall_md;
  logic [31:0] hi, lo, rd_val;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  exe_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .op_i       (op),
    .rs_val_i   (rs),
    .rt_val_i   (rt),
    .cancel_i   (cancel),
    .busy_o     (busy),
    .stall_md_o (stall_md),
    .hi_o       (hi),
    .lo_o       (lo),
    .rd_val_o   (rd_val)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {hi,lo} after the op, from current hi/lo h,l.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur, acc;
    sa  = longint'(signed'(a));
    sbv = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    case (o)
      OP_MULT:  return sa * sbv;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {h, l};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      OP_MADD:  return acc + longint'(sa * sbv);
      OP_MADDU: return acc + ua * ub;
      OP_MSUB:  return acc - longint'(sa * sbv);
      OP_MSUBU: return acc - ua * ub;
      default:  return {h, l};
    endcase
  endfunction

  // Issue a mult/div, check stall/busy timing, then pop and compare result.
  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    exp_t e;
    logic [63:0] r;
    int cnt;
    r = model(o, a, b, m_hi, m_lo);
    e.hi = r[63:32];
    e.lo = r[31:0];
    sb.push_back(e);
    start = 1'b1; op = o; rs = a; rt = b;
    #1;
    chk({tag, "_stall_start"}, 64'(stall_md), 64'd1);
    chk({tag, "_busy_start"}, 64'(busy), 64'd0);
    tick();
    start = 1'b0; op = OP_NONE;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      chk({tag, "_stall_busy"}, 64'(stall_md), 64'd1);
      tick();
    end
    chk({tag, "_busy_len"}, 64'(cnt), 64'(n));
    chk({tag, "_stall_after"}, 64'(stall_md), 64'd0);
    e = sb.pop_front();
    chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic mt(input string tag, input logic [3:0] o, input logic [31:0] v);
    start = 1'b1; op = o; rs = v;
    #1;
    chk({tag, "_stall"}, 64'(stall_md), 64'd0);
    tick();
    start = 1'b0; op = OP_NONE;
    if (o == OP_MTHI) m_hi = v; else m_lo = v;
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_NONE; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall_md), 64'd0);
    chk("rst_rd", 64'(rd_val), 64'd0);

    run_md("mult",  OP_MULT,  32'hFFFF_FFFF, 32'd2, MC);
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC);
    chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_md("div",   OP_DIV,   32'hFFFF_FFF9, 32'd2, DC);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("divu",  OP_DIVU,  32'd7, 32'd2, DC);
    chk("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    run_md("mult_mix", OP_MULT, 32'h1234_5678, 32'h8765_4321, MC);

    // divide by zero leaves preset HI/LO
    mt("mthi", OP_MTHI, 32'h11);
    mt("mtlo", OP_MTLO, 32'h22);
    run_md("divu_z", OP_DIVU, 32'd7, 32'd0, DC);
    chk("divz_const", {hi, lo}, 64'h0000_0011_0000_0022);
    op = OP_MFHI; start = 1'b1; #1;
    chk("mfhi_rd", 64'(rd_val), 64'h11);
    op = OP_MFLO; #1;
    chk("mflo_rd", 64'(rd_val), 64'h22);
    op = OP_NONE; #1;
    chk("none_rd", 64'(rd_val), 64'd0);
    start = 1'b0;
    tick();

    // cancel on busy cycle 3
    start = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
    tick();
    start = 1'b0; op = OP_NONE;
    chk("cx_busy1", 64'(busy), 64'd1);
    tick(); tick();
    cancel = 1'b1;
    #1;
    chk("cx_stall3", 64'(stall_md), 64'd1);
    tick();
    cancel = 1'b0;
    chk("cx_busy_off", 64'(busy), 64'd0);
    chk("cx_stall_off", 64'(stall_md), 64'd0);
    repeat (6) tick();
    chk("cx_hi", 64'(hi), 64'(m_hi));
    chk("cx_lo", 64'(lo), 64'(m_lo));

    // cancel on the commit cycle beats the commit
    start = 1'b1; op = OP_DIVU; rs = 32'd100; rt = 32'd7;
    tick();
    start = 1'b0; op = OP_NONE;
    repeat (DC - 1) tick();
    chk("cxl_busy_last", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cxl_busy", 64'(busy), 64'd0);
    tick();
    chk("cxl_hilo", {hi, lo}, {m_hi, m_lo});

    // cancel suppresses start, including mt*
    start = 1'b1; cancel = 1'b1; op = OP_MULT; rs = 32'd9; rt = 32'd9;
    #1;
    chk("cxs_stall", 64'(stall_md), 64'd0);
    tick();
    chk("cxs_busy", 64'(busy), 64'd0);
    op = OP_MTLO; rs = 32'h5;
    tick();
    start = 1'b0; cancel = 1'b0; op = OP_NONE;
    chk("cxmt_lo", 64'(lo), 64'(m_lo));
    chk("cxmt_busy", 64'(busy), 64'd0);

`ifdef MDU_MADD_EN
    run_md("madd",  OP_MADD,  32'hFFFF_FFFE, 32'd3, MC);
    run_md("msubu", OP_MSUBU, 32'd5, 32'd6, MC);
`else
    start = 1'b1; op = OP_MADD; rs = 32'd5; rt = 32'd6;
    #1;
    chk("op9_stall", 64'(stall_md), 64'd0);
    chk("op9_rd", 64'(rd_val), 64'd0);
    tick();
    start = 1'b0; op = OP_NONE;
    chk("op9_busy", 64'(busy), 64'd0);
    chk("op9_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    // reset in the middle of a divide
    mt("mthi2", OP_MTHI, 32'hABCD);
    start = 1'b1; op = OP_DIV; rs = 32'd50; rt = 32'd3;
    tick();
    start = 1'b0; op = OP_NONE;
    repeat (3) tick();
    chk("rdiv_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rdiv_busy_off", 64'(busy), 64'd0);
    chk("rdiv_hi", 64'(hi), 64'd0);
    chk("rdiv_lo", 64'(lo), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (DC) tick();
    chk("rdiv_hilo_late", {hi, lo}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
